cv32e40p_glitch_alarm_ctrl: RTL and testbench

Central responder for the clock-glitch detector alarms. Collects single-cycle alarm pulses from NUM_DET delay-line detectors, records which detectors fired, halts the core for a fixed recovery interval, raises an interrupt until software acknowledges, and escalates to a permanent lockout when too many events arrive within a time window. Sits between the detector instances and the core's fetch-disable and interrupt inputs.

---
 rtl/cv32e40p_glitch_alarm_ctrl.sv | 168 ++++++++++++++++
 tb/tb_cv32e40p_glitch_alarm_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/cv32e40p_glitch_alarm_ctrl.sv
// cv32e40p_glitch_alarm_ctrl
// Central responder for the clock-glitch detector alarms. It records which
// detectors fired, halts the core for a recovery interval after the last event,
// and holds an interrupt until software acknowledges it. Too many events inside
// one escalation window cause a permanent lockout that only reset can clear.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   alarm_i      one-cycle alarm pulses from the detectors (any set bit = event)
//   ack_i        software acknowledge, level sampled each cycle
//   core_halt_o  fetch-disable / halt request to the core
//   irq_o        alarm interrupt
//   lockout_o    permanent lockout indication
//   alarm_src_o  sticky record of the detectors that fired
//   event_cnt_o  cumulative saturating event count
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | no pending alarm
// HOLD     | core halted, recovery timer running, interrupt raised
// WAIT_ACK | core running, interrupt held until software acknowledges
// LOCKOUT  | too many events in one window; terminal until reset
module cv32e40p_glitch_alarm_ctrl #(
  parameter int NUM_DET       = 4,
  parameter int CNT_W         = 8,
  parameter int HOLD_CYCLES   = 16,
  parameter int WINDOW_CYCLES = 1024,
  parameter int LOCK_THRESH   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_DET-1:0] alarm_i,
  input  logic               ack_i,
  output logic               core_halt_o,
  output logic               irq_o,
  output logic               lockout_o,
  output logic [NUM_DET-1:0] alarm_src_o,
  output logic [CNT_W-1:0]   event_cnt_o
);

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int WIN_W  = $clog2(WINDOW_CYCLES);
  localparam int WEV_W  = $clog2(LOCK_THRESH + 1);

  localparam logic [HOLD_W-1:0] HOLD_LOAD  = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [WIN_W-1:0]  WIN_LAST   = WIN_W'(WINDOW_CYCLES - 1);
  localparam logic [WEV_W-1:0]  WEV_THRESH = WEV_W'(LOCK_THRESH);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_HOLD     = 2'd1,
    S_WAIT_ACK = 2'd2,
    S_LOCKOUT  = 2'd3
  } state_e;

  state_e              r_state;
  logic [HOLD_W-1:0]   r_hold_cnt;
  logic                r_win_active;
  logic [WIN_W-1:0]    r_win_timer;
  logic [WEV_W-1:0]    r_win_events;
  logic                r_halt;
  logic                r_irq;
  logic                r_lock;
  logic [NUM_DET-1:0]  r_src;
  logic [CNT_W-1:0]    r_cnt;

  logic                w_event;
  logic                w_win_active_nxt;
  logic [WIN_W-1:0]    w_win_timer_nxt;
  logic [WEV_W-1:0]    w_win_events_nxt;
  logic                w_lock_trig;
  state_e              w_state_nxt;

  assign w_event = |alarm_i;

  // Escalation window. An event on the closing cycle starts a fresh window
  // instead of being lost. The event count saturates at the threshold since
  // lockout is terminal anyway.
  always_comb begin
    w_win_active_nxt = r_win_active;
    w_win_timer_nxt  = r_win_timer;
    w_win_events_nxt = r_win_events;
    if (!r_win_active) begin
      if (w_event) begin
        w_win_active_nxt = 1'b1;
        w_win_timer_nxt  = '0;
        w_win_events_nxt = WEV_W'(1);
      end
    end else if (r_win_timer == WIN_LAST) begin
      w_win_timer_nxt = '0;
      if (w_event) begin
        w_win_events_nxt = WEV_W'(1);
      end else begin
        w_win_active_nxt = 1'b0;
        w_win_events_nxt = '0;
      end
    end else begin
      w_win_timer_nxt = r_win_timer + 1'b1;
      if (w_event && (r_win_events != WEV_THRESH)) begin
        w_win_events_nxt = r_win_events + 1'b1;
      end
    end
  end

  assign w_lock_trig = (w_win_events_nxt == WEV_THRESH);

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:     if (w_event) w_state_nxt = S_HOLD;
      S_HOLD:     if (!w_event && (r_hold_cnt == '0)) w_state_nxt = S_WAIT_ACK;
      S_WAIT_ACK: begin
        if (w_event)    w_state_nxt = S_HOLD;
        else if (ack_i) w_state_nxt = S_IDLE;
      end
      S_LOCKOUT:  w_state_nxt = S_LOCKOUT;
      default:    w_state_nxt = S_IDLE;
    endcase
    if (w_lock_trig) w_state_nxt = S_LOCKOUT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_hold_cnt   <= '0;
      r_win_active <= 1'b0;
      r_win_timer  <= '0;
      r_win_events <= '0;
      r_halt       <= 1'b0;
      r_irq        <= 1'b0;
      r_lock       <= 1'b0;
      r_src        <= '0;
      r_cnt        <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_win_active <= w_win_active_nxt;
      r_win_timer  <= w_win_timer_nxt;
      r_win_events <= w_win_events_nxt;

      if (w_event) begin
        r_hold_cnt <= HOLD_LOAD;
      end else if ((r_state == S_HOLD) && (r_hold_cnt != '0)) begin
        r_hold_cnt <= r_hold_cnt - 1'b1;
      end

      if (w_event && (r_cnt != '1)) r_cnt <= r_cnt + 1'b1;

      // Ack only clears sources when it actually retires the alarm.
      if (w_event) begin
        r_src <= r_src | alarm_i;
      end else if ((r_state == S_WAIT_ACK) && ack_i) begin
        r_src <= '0;
      end

      r_halt <= (w_state_nxt == S_HOLD) || (w_state_nxt == S_LOCKOUT);
      r_irq  <= (w_state_nxt != S_IDLE);
      r_lock <= (w_state_nxt == S_LOCKOUT);
    end
  end

  assign core_halt_o = r_halt;
  assign irq_o       = r_irq;
  assign lockout_o   = r_lock;
  assign alarm_src_o = r_src;
  assign event_cnt_o = r_cnt;

endmodule

// File: tb/tb_cv32e40p_glitch_alarm_ctrl.sv
// Directed bench for cv32e40p_glitch_alarm_ctrl. A default-parameter instance
// covers hold timing, acknowledge, escalation and reset; a second instance with
// a short window and hold covers counter saturation and the window-close edge.
module tb_cv32e40p_glitch_alarm_ctrl;

  logic       clk;
  logic       rst_n;
  logic [3:0] alarm_m;
  logic       ack_m;
  logic [3:0] alarm_s;
  logic       ack_s;

  logic       halt_m, irq_m, lock_m;
  logic [3:0] src_m;
  logic [7:0] cnt_m;
  logic       halt_s, irq_s, lock_s;
  logic [3:0] src_s;
  logic [7:0] cnt_s;

  logic [14:0] act_m;
  logic [14:0] act_s;
  assign act_m = {halt_m, irq_m, lock_m, src_m, cnt_m};
  assign act_s = {halt_s, irq_s, lock_s, src_s, cnt_s};

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    bit          sel;
    logic [14:0] v;
  } exp_t;
  exp_t q[$];

  cv32e40p_glitch_alarm_ctrl #(
    .NUM_DET(4), .CNT_W(8), .HOLD_CYCLES(16), .WINDOW_CYCLES(1024), .LOCK_THRESH(4)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .alarm_i(alarm_m), .ack_i(ack_m),
    .core_halt_o(halt_m), .irq_o(irq_m), .lockout_o(lock_m),
    .alarm_src_o(src_m), .event_cnt_o(cnt_m)
  );

  cv32e40p_glitch_alarm_ctrl #(
    .NUM_DET(4), .CNT_W(8), .HOLD_CYCLES(2), .WINDOW_CYCLES(8), .LOCK_THRESH(4)
  ) u_dut_s (
    .clk(clk), .rst_n(rst_n), .alarm_i(alarm_s), .ack_i(ack_s),
    .core_halt_o(halt_s), .irq_o(irq_s), .lockout_o(lock_s),
    .alarm_src_o(src_s), .event_cnt_o(cnt_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [14:0] pk(input logic h, input logic i, input logic l,
                                     input logic [3:0] s, input logic [7:0] c);
    return {h, i, l, s, c};
  endfunction

  task automatic check_pop();
    exp_t e;
    logic [14:0] act;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = q.pop_front();
      act = e.sel ? act_s : act_m;
      assert (act === e.v) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", e.tag, act, e.v);
      end
    end
  endtask

  task automatic chk_now(input bit sel, input string tag, input logic [14:0] v);
    q.push_back('{tag, sel, v});
    check_pop();
  endtask

  // Drive one cycle of inputs, expect the given outputs right after the edge.
  task automatic step(input bit sel, input logic [3:0] a, input logic k,
                      input string tag, input logic [14:0] v);
    if (sel) alarm_s = a;
    else begin
      alarm_m = a;
      ack_m   = k;
    end
    q.push_back('{tag, sel, v});
    @(posedge clk);
    #1;
    alarm_s = '0;
    alarm_m = '0;
    ack_m   = 1'b0;
    check_pop();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [7:0] ce;
    rst_n   = 1'b0;
    alarm_m = '0;
    ack_m   = 1'b0;
    alarm_s = '0;
    ack_s   = 1'b0;
    #12;
    chk_now(0, "reset_main", pk(0, 0, 0, 4'b0000, 8'd0));
    chk_now(1, "reset_small", pk(0, 0, 0, 4'b0000, 8'd0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Saturation on the short-window instance: spacing exceeds the window.
    for (int i = 0; i < 300; i++) begin
      ce = (i + 1 > 255) ? 8'd255 : 8'(i + 1);
      step(1, 4'b0001, 1'b0, "sat_cnt", pk(1, 1, 0, 4'b0001, ce));
      idle(9);
    end
    idle(10);

    // Window-close edge: the event on the closing cycle opens a fresh window.
    step(1, 4'b0001, 1'b0, "win_e1", pk(1, 1, 0, 4'b0001, 8'd255));
    step(1, 4'b0001, 1'b0, "win_e2", pk(1, 1, 0, 4'b0001, 8'd255));
    step(1, 4'b0001, 1'b0, "win_e3", pk(1, 1, 0, 4'b0001, 8'd255));
    idle(5);
    step(1, 4'b0001, 1'b0, "win_close_evt", pk(1, 1, 0, 4'b0001, 8'd255));
    step(1, 4'b0001, 1'b0, "win_fresh2", pk(1, 1, 0, 4'b0001, 8'd255));
    step(1, 4'b0001, 1'b0, "win_fresh3", pk(1, 1, 0, 4'b0001, 8'd255));
    step(1, 4'b0001, 1'b0, "win_fresh4_lock", pk(1, 1, 1, 4'b0001, 8'd255));

    // Single pulse, full hold, then acknowledge.
    step(0, 4'b0010, 1'b0, "t1_event", pk(1, 1, 0, 4'b0010, 8'd1));
    for (int k = 0; k < 15; k++) step(0, 4'b0000, 1'b0, "t1_hold", pk(1, 1, 0, 4'b0010, 8'd1));
    step(0, 4'b0000, 1'b0, "t1_release", pk(0, 1, 0, 4'b0010, 8'd1));
    for (int k = 0; k < 3; k++) step(0, 4'b0000, 1'b0, "t1_wait", pk(0, 1, 0, 4'b0010, 8'd1));
    step(0, 4'b0000, 1'b1, "t1_ack", pk(0, 0, 0, 4'b0000, 8'd1));
    idle(1100);

    // Second event during hold extends it and merges sources.
    step(0, 4'b1001, 1'b0, "t2_event1", pk(1, 1, 0, 4'b1001, 8'd2));
    for (int k = 0; k < 9; k++) step(0, 4'b0000, 1'b0, "t2_hold1", pk(1, 1, 0, 4'b1001, 8'd2));
    step(0, 4'b0100, 1'b0, "t2_event2", pk(1, 1, 0, 4'b1101, 8'd3));
    for (int k = 0; k < 15; k++) step(0, 4'b0000, 1'b0, "t2_hold2", pk(1, 1, 0, 4'b1101, 8'd3));
    step(0, 4'b0000, 1'b0, "t2_release", pk(0, 1, 0, 4'b1101, 8'd3));
    step(0, 4'b0000, 1'b1, "t2_ack", pk(0, 0, 0, 4'b0000, 8'd3));
    idle(1100);

    // Event and ack in the same WAIT_ACK cycle: event wins.
    step(0, 4'b0001, 1'b0, "t3_event", pk(1, 1, 0, 4'b0001, 8'd4));
    for (int k = 0; k < 15; k++) idle(1);
    step(0, 4'b0000, 1'b0, "t3_wait", pk(0, 1, 0, 4'b0001, 8'd4));
    step(0, 4'b1000, 1'b1, "t3_evt_ack", pk(1, 1, 0, 4'b1001, 8'd5));
    step(0, 4'b0000, 1'b1, "t3_ack_in_hold", pk(1, 1, 0, 4'b1001, 8'd5));
    idle(20);
    step(0, 4'b0000, 1'b1, "t3_ack", pk(0, 0, 0, 4'b0000, 8'd5));
    idle(1100);

    // Four events 100 cycles apart reach the threshold.
    step(0, 4'b0001, 1'b0, "t4_ev1", pk(1, 1, 0, 4'b0001, 8'd6));
    idle(99);
    step(0, 4'b0001, 1'b0, "t4_ev2", pk(1, 1, 0, 4'b0001, 8'd7));
    idle(99);
    step(0, 4'b0001, 1'b0, "t4_ev3", pk(1, 1, 0, 4'b0001, 8'd8));
    idle(99);
    step(0, 4'b0001, 1'b0, "t4_lock", pk(1, 1, 1, 4'b0001, 8'd9));
    step(0, 4'b0000, 1'b1, "t4_ack_ignored", pk(1, 1, 1, 4'b0001, 8'd9));
    idle(50);
    step(0, 4'b0000, 1'b1, "t4_still_locked", pk(1, 1, 1, 4'b0001, 8'd9));

    // Asynchronous reset out of lockout.
    #3;
    rst_n = 1'b0;
    #1;
    chk_now(0, "t4_async_reset", pk(0, 0, 0, 4'b0000, 8'd0));
    chk_now(1, "t4_async_reset_s", pk(0, 0, 0, 4'b0000, 8'd0));
    @(posedge clk);
    #1;
    chk_now(0, "t4_reset_held", pk(0, 0, 0, 4'b0000, 8'd0));
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Two acked groups of three, separated by more than a window.
    for (int g = 0; g < 2; g++) begin
      for (int e = 0; e < 3; e++) begin
        step(0, 4'b0001, 1'b0, "t5_event", pk(1, 1, 0, 4'b0001, 8'(g * 3 + e + 1)));
        idle(20);
        step(0, 4'b0000, 1'b1, "t5_ack", pk(0, 0, 0, 4'b0000, 8'(g * 3 + e + 1)));
      end
      idle(1100);
    end

    // Reset during HOLD, then a fresh event behaves as from IDLE.
    step(0, 4'b0100, 1'b0, "t6_event", pk(1, 1, 0, 4'b0100, 8'd7));
    idle(5);
    #3;
    rst_n = 1'b0;
    #1;
    chk_now(0, "t6_async_reset", pk(0, 0, 0, 4'b0000, 8'd0));
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(0, 4'b0010, 1'b0, "t6_post_event", pk(1, 1, 0, 4'b0010, 8'd1));
    for (int k = 0; k < 15; k++) step(0, 4'b0000, 1'b0, "t6_hold", pk(1, 1, 0, 4'b0010, 8'd1));
    step(0, 4'b0000, 1'b0, "t6_release", pk(0, 1, 0, 4'b0010, 8'd1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
